rr_logging_bus_merge_n: RTL and testbench
=========================================

RR_LOGGING_BUS_MERGE_N -- requirements
Module: rr_logging_bus_merge_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 5: number of logging channels merged, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 64: payload width per channel.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: per-channel buffer entries, power of two, at least 2.
REQ-004 SHALL derive localparam ID_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  NUM_CH  per-channel record valid.
REQ-008 SHALL have port in_data  input  NUM_CH*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port in_ready  output  NUM_CH  per-channel accept.
REQ-010 SHALL have port out_valid  output  1  merged record valid.
REQ-011 SHALL have port out_data  output  DATA_W  merged payload.
REQ-012 SHALL have port out_id  output  ID_W  source channel index of out_data.
REQ-013 SHALL have port out_ready  input  1  downstream accept.
REQ-014 SHALL have port fifo_full  output  NUM_CH  per-channel buffer-full status.
REQ-015 SHALL have port stall_cnt  output  32  output backpressure cycle count.

Function
REQ-016 SHALL accept a record on channel i when in_valid[i] && in_ready[i] at a rising edge, writing it into FIFO i.
REQ-017 SHALL drive in_ready[i] = !fifo_full[i], derived from occupancy only, independent of in_valid and out_ready.
REQ-018 SHALL refuse a push on a full FIFO even when a pop of that FIFO occurs in the same cycle.
REQ-019 SHALL allow simultaneous push and pop on a non-full, non-empty FIFO, leaving occupancy unchanged.
REQ-020 SHALL treat the output as a single register stage; the stage is loadable when !out_valid || out_ready.
REQ-021 SHALL, when loadable, grant the first non-empty FIFO searching from (last_grant+1) mod NUM_CH upward with wrap-around.
REQ-022 SHALL, on grant, pop that FIFO head into out_data, set out_id to the channel index, assert out_valid, and set last_grant to that channel.
REQ-023 SHALL, when loadable and all FIFOs are empty, deassert out_valid on the next edge and leave last_grant unchanged.
REQ-024 SHALL hold out_data and out_id stable while out_valid && !out_ready.
REQ-025 SHALL provide minimum latency of 2 cycles, from an input accepted at edge t (all FIFOs and output empty) to out_valid high after edge t+1.
REQ-026 SHALL sustain one output record per cycle while any FIFO is non-empty and out_ready is held high.
REQ-027 SHALL preserve per-channel ordering; cross-channel order is defined solely by REQ-021.
REQ-028 SHALL guarantee that no channel waits more than NUM_CH grants once its FIFO is non-empty.

Reset
REQ-029 SHALL, on rstn low, asynchronously empty all FIFOs, and clear out_valid, out_data, out_id, and stall_cnt to 0.
REQ-030 SHALL, on rstn low, set last_grant to NUM_CH-1 so that channel 0 has first priority; in_ready is all-ones after reset.
REQ-031 SHALL discard in-flight records on reset mid-operation without emitting them after release.

Configuration
REQ-032 SHALL, with RR_MERGE_STALL_CNT_EN defined, increment stall_cnt each cycle out_valid && !out_ready holds, saturating at 32'hFFFFFFFF.
REQ-033 SHALL, without RR_MERGE_STALL_CNT_EN, tie stall_cnt to 0 and synthesise no counter logic; the port remains present.

Verification
REQ-034 SHALL cover: reset, push 0xA5 on ch2 only -> out_valid after 2 edges, out_data=0xA5, out_id=2.
REQ-035 SHALL cover: all 5 channels push one record in the same cycle, out_ready=1 -> out_id sequence 0,1,2,3,4 on consecutive cycles.
REQ-036 SHALL cover: out_ready=0, ch0 pushes 6 records (FIFO_DEPTH=4) -> 5 accepted (4 buffered + 1 in output), in_ready[0]=0, fifo_full[0]=1, out_data stable.
REQ-037 SHALL cover: with macro on, out_valid held 10 cycles with out_ready=0 -> stall_cnt=10; with macro off -> stall_cnt=0.
REQ-038 SHALL cover: ch1 and ch3 saturated continuously -> grants strictly alternate 1,3,1,3 with no loss and in-order payloads.
REQ-039 SHALL cover: rstn asserted with 3 records buffered -> out_valid=0 immediately, no record emitted after release, first new push on ch0 is granted first.

Source files
------------

// File: rtl/rr_logging_bus_merge_n.sv
// Round-robin merge of NUM_CH logging channels through per-channel FIFOs into one registered output.
// Optional backpressure counter on stall_cnt is enabled by defining RR_MERGE_STALL_CNT_EN.

module rr_logging_bus_merge_n_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic              do_push, do_pop;

  // a full FIFO refuses a push even if it is popped in the same cycle
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

module rr_logging_bus_merge_n #(
  parameter int NUM_CH     = 5,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        fifo_full,
  output logic [31:0]              stall_cnt
);
  logic [NUM_CH-1:0][DATA_W-1:0] fifo_dout;
  logic [NUM_CH-1:0]             fifo_empty;
  logic [NUM_CH-1:0]             pop;
  logic [ID_W-1:0]               last_grant;
  logic [ID_W-1:0]               gnt_idx;
  logic                          gnt_found;
  logic                          loadable;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rr_logging_bus_merge_n_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (in_valid[g]),
      .din   (in_data[g*DATA_W +: DATA_W]),
      .pop   (pop[g]),
      .dout  (fifo_dout[g]),
      .empty (fifo_empty[g]),
      .full  (fifo_full[g])
    );
  end

  assign in_ready = ~fifo_full;
  assign loadable = !out_valid || out_ready;

  // first non-empty channel after last_grant, wrapping at NUM_CH
  always_comb begin
    int c;
    c         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(last_grant) + 1 + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!gnt_found && !fifo_empty[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(c);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (loadable && gnt_found) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      last_grant <= ID_W'(NUM_CH-1);
    end else if (loadable) begin
      out_valid <= gnt_found;
      if (gnt_found) begin
        out_data   <= fifo_dout[gnt_idx];
        out_id     <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end

`ifdef RR_MERGE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_rr_logging_bus_merge_n.sv
// Directed bench for rr_logging_bus_merge_n: vector table plus hand sequences for
// backpressure, stall counting, two-channel saturation and mid-run reset.
module tb_rr_logging_bus_merge_n;
  localparam int NUM_CH = 5;
  localparam int DATA_W = 64;

  logic                     clk;
  logic                     rstn;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [2:0]               out_id;
  logic                     out_ready;
  logic [NUM_CH-1:0]        fifo_full;
  logic [31:0]              stall_cnt;

  int total = 0;
  int bad   = 0;

  rr_logging_bus_merge_n #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .fifo_full (fifo_full),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] iv;
    logic [63:0]       base;
    logic              ordy;
    logic              ev;
    logic [2:0]        eid;
    logic [63:0]       ed;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        tbl[18];
    logic [31:0] exp_stall;
    int          acc;
    int          sent[2];
    int          rcv[2];
    logic [2:0]  exp_id;
    logic        a1, a3;
    int          k;

`ifdef RR_MERGE_STALL_CNT_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif

    // channel c payload in table vectors = base + c*0x10
    tbl[0]  = '{5'b11111, 64'h100, 1'b1, 1'b0, 3'd0, 64'h0};
    tbl[1]  = '{5'b00000, 64'h0,   1'b1, 1'b1, 3'd0, 64'h100};
    tbl[2]  = '{5'b00000, 64'h0,   1'b1, 1'b1, 3'd1, 64'h110};
    tbl[3]  = '{5'b00000, 64'h0,   1'b1, 1'b1, 3'd2, 64'h120};
    tbl[4]  = '{5'b00000, 64'h0,   1'b1, 1'b1, 3'd3, 64'h130};
    tbl[5]  = '{5'b00000, 64'h0,   1'b1, 1'b1, 3'd4, 64'h140};
    tbl[6]  = '{5'b00000, 64'h0,   1'b1, 1'b0, 3'd0, 64'h0};
    tbl[7]  = '{5'b00100, 64'h85,  1'b1, 1'b0, 3'd0, 64'h0};
    tbl[8]  = '{5'b00000, 64'h0,   1'b1, 1'b1, 3'd2, 64'hA5};
    tbl[9]  = '{5'b00000, 64'h0,   1'b1, 1'b0, 3'd0, 64'h0};
    tbl[10] = '{5'b00011, 64'h200, 1'b1, 1'b0, 3'd0, 64'h0};
    tbl[11] = '{5'b00000, 64'h0,   1'b1, 1'b1, 3'd0, 64'h200};
    tbl[12] = '{5'b00000, 64'h0,   1'b1, 1'b1, 3'd1, 64'h210};
    tbl[13] = '{5'b00000, 64'h0,   1'b1, 1'b0, 3'd0, 64'h0};
    tbl[14] = '{5'b10000, 64'h300, 1'b0, 1'b0, 3'd0, 64'h0};
    tbl[15] = '{5'b00000, 64'h0,   1'b0, 1'b1, 3'd4, 64'h340};
    tbl[16] = '{5'b00000, 64'h0,   1'b0, 1'b1, 3'd4, 64'h340};
    tbl[17] = '{5'b00000, 64'h0,   1'b1, 1'b0, 3'd0, 64'h0};

    // reset state
    do_reset();
    chk("rst out_valid", 64'(out_valid), 64'h0);
    chk("rst out_data", out_data, 64'h0);
    chk("rst out_id", 64'(out_id), 64'h0);
    chk("rst in_ready", 64'(in_ready), 64'h1f);
    chk("rst fifo_full", 64'(fifo_full), 64'h0);
    chk("rst stall_cnt", 64'(stall_cnt), 64'h0);

    // table vectors: all-channel round, single ch2 0xA5, wrap-around, held output
    for (int i = 0; i < 18; i++) begin
      in_valid = tbl[i].iv;
      for (int c = 0; c < NUM_CH; c++)
        in_data[c*DATA_W +: DATA_W] = tbl[i].base + 64'(c) * 64'h10;
      out_ready = tbl[i].ordy;
      step();
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d out_id", i), 64'(out_id), 64'(tbl[i].eid));
        chk($sformatf("vec%0d out_data", i), out_data, tbl[i].ed);
      end
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'h1f);
    end

    // ch0 overfill under backpressure; full FIFO refuses push even while popped
    do_reset();
    acc = 0;
    for (int n = 0; n < 6; n++) begin
      in_valid = 5'b00001;
      in_data[0 +: DATA_W] = 64'h1000 + 64'(n);
      if (in_ready[0]) acc++;
      step();
    end
    chk("ovf accepted", 64'(acc), 64'd5);
    chk("ovf in_ready0", 64'(in_ready[0]), 64'h0);
    chk("ovf fifo_full0", 64'(fifo_full[0]), 64'h1);
    chk("ovf out_valid", 64'(out_valid), 64'h1);
    chk("ovf out_data", out_data, 64'h1000);
    step();
    chk("ovf hold data", out_data, 64'h1000);
    chk("ovf hold id", 64'(out_id), 64'h0);
    in_data[0 +: DATA_W] = 64'h1006;
    out_ready = 1'b1;
    step();
    in_valid = '0;
    chk("ovf drain0", out_data, 64'h1001);
    for (int n = 2; n < 5; n++) begin
      step();
      chk($sformatf("ovf drain%0d", n - 1), out_data, 64'h1000 + 64'(n));
    end
    step();
    chk("ovf drained", 64'(out_valid), 64'h0);

    // stall counter
    do_reset();
    in_valid = 5'b00010;
    in_data[1*DATA_W +: DATA_W] = 64'h77;
    step();
    in_valid = '0;
    step();
    chk("stall out_valid", 64'(out_valid), 64'h1);
    chk("stall start", 64'(stall_cnt), 64'h0);
    repeat (10) step();
    chk("stall count", 64'(stall_cnt), 64'(exp_stall));
    chk("stall data", out_data, 64'h77);
    out_ready = 1'b1;
    step();
    chk("stall drained", 64'(out_valid), 64'h0);
    chk("stall kept", 64'(stall_cnt), 64'(exp_stall));

    // ch1 and ch3 saturated: strict alternation, per-channel order
    do_reset();
    out_ready = 1'b1;
    sent[0] = 0; sent[1] = 0; rcv[0] = 0; rcv[1] = 0;
    exp_id = 3'd1;
    for (int n = 0; n < 40; n++) begin
      in_valid = 5'b01010;
      in_data[1*DATA_W +: DATA_W] = {32'h1, 32'(sent[0])};
      in_data[3*DATA_W +: DATA_W] = {32'h3, 32'(sent[1])};
      a1 = in_ready[1];
      a3 = in_ready[3];
      step();
      if (a1) sent[0]++;
      if (a3) sent[1]++;
      if (n >= 1) begin
        k = (exp_id == 3'd1) ? 0 : 1;
        chk($sformatf("alt%0d valid", n), 64'(out_valid), 64'h1);
        chk($sformatf("alt%0d id", n), 64'(out_id), 64'(exp_id));
        chk($sformatf("alt%0d data", n), out_data, {29'h0, exp_id, 32'(rcv[k])});
        rcv[k]++;
        exp_id = (exp_id == 3'd1) ? 3'd3 : 3'd1;
      end
    end
    in_valid = '0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (out_valid) begin
        chk("drain id legal", 64'(out_id == 3'd1 || out_id == 3'd3), 64'h1);
        k = (out_id == 3'd3) ? 1 : 0;
        chk($sformatf("drain%0d data", n), out_data, {29'h0, out_id, 32'(rcv[k])});
        rcv[k]++;
      end
    end
    chk("no loss ch1", 64'(rcv[0]), 64'(sent[0]));
    chk("no loss ch3", 64'(rcv[1]), 64'(sent[1]));

    // reset mid-operation
    do_reset();
    in_valid = 5'b01110;
    for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = 64'hE0 + 64'(c);
    step();
    in_valid = '0;
    step();
    chk("mid out_valid", 64'(out_valid), 64'h1);
    chk("mid out_id", 64'(out_id), 64'h1);
    #2 rstn = 1'b0;
    #1;
    chk("async rst valid", 64'(out_valid), 64'h0);
    chk("async rst data", out_data, 64'h0);
    chk("async rst ready", 64'(in_ready), 64'h1f);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("post rst idle%0d", n), 64'(out_valid), 64'h0);
    end
    in_valid = 5'b10001;
    in_data[0*DATA_W +: DATA_W] = 64'hC0;
    in_data[4*DATA_W +: DATA_W] = 64'hC4;
    step();
    in_valid = '0;
    step();
    chk("post rst first id", 64'(out_id), 64'h0);
    chk("post rst first data", out_data, 64'hC0);
    step();
    chk("post rst second id", 64'(out_id), 64'h4);
    chk("post rst second data", out_data, 64'hC4);
    step();
    chk("post rst empty", 64'(out_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
